// File: rtl/xoodyak_frame_loader.sv
// Word-stream front end for xoodyak_build: packs one frame of operands, fires a one-cycle start, holds until done.
// Optional build macro XOODYAK_LOADER_SHORTENC_EN: opmode=0 frames end at word 17 and verif_data is forced to 0.
module xoodyak_frame_loader #(
    parameter int DW       = 32,
    parameter int BLK_BITS = 128,
    parameter int TXT_BITS = 192
) (
    input  logic                eph1,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic                in_last,
    input  logic                in_opmode,
    input  logic                core_done,
    input  logic                err_clr,
    output logic [BLK_BITS-1:0] key,
    output logic [BLK_BITS-1:0] nonce,
    output logic [BLK_BITS-1:0] assodata,
    output logic [TXT_BITS-1:0] textin,
    output logic [BLK_BITS-1:0] verif_data,
    output logic                opmode,
    output logic                start,
    output logic                busy,
    output logic                err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FIRE = 2'd2;
    localparam logic [1:0] S_BUSY = 2'd3;

    localparam logic [4:0] LAST_FULL  = 5'd21;
    localparam logic [4:0] LAST_SHORT = 5'd17;

    logic [1:0]          state_q, state_d;
    logic [4:0]          wcnt_q, wcnt_d;
    logic [BLK_BITS-1:0] key_q, key_d;
    logic [BLK_BITS-1:0] nonce_q, nonce_d;
    logic [BLK_BITS-1:0] ad_q, ad_d;
    logic [TXT_BITS-1:0] text_q, text_d;
    logic [BLK_BITS-1:0] verif_q, verif_d;
    logic                opmode_q, opmode_d;
    logic                err_q, err_d;

    logic                accept;
    logic [4:0]          idx;
    logic                cur_op;
    logic [4:0]          last_idx;
    logic                is_final;
    logic                frame_err;
    logic [2:0]          toff;
    logic [1:0]          voff;

    assign in_ready = reset_n & ((state_q == S_IDLE) | (state_q == S_LOAD));
    assign accept   = in_valid & in_ready;

    // Word 0 arrives in IDLE, where wcnt is 0 and opmode has not been latched yet.
    assign idx    = (state_q == S_IDLE) ? 5'd0 : wcnt_q;
    assign cur_op = (state_q == S_IDLE) ? in_opmode : opmode_q;

    always_comb begin
        last_idx = LAST_FULL;
`ifdef XOODYAK_LOADER_SHORTENC_EN
        if (!cur_op) begin
            last_idx = LAST_SHORT;
        end
`else
        if (cur_op && (last_idx == LAST_SHORT)) begin
            last_idx = LAST_FULL;
        end
`endif
    end

    assign is_final = (idx == last_idx);
    assign toff     = 3'(idx - 5'd12);
    assign voff     = 2'(idx - 5'd18);

    // Operand write decode: each accepted word lands in its field at the slot given by idx.
    always_comb begin
        key_d    = key_q;
        nonce_d  = nonce_q;
        ad_d     = ad_q;
        text_d   = text_q;
        verif_d  = verif_q;
        opmode_d = opmode_q;
        if (accept) begin
            if (state_q == S_IDLE) begin
                opmode_d = in_opmode;
            end
            if (idx < 5'd4) begin
                key_d[{idx[1:0], 5'd0} +: DW] = in_data;
            end else if (idx < 5'd8) begin
                nonce_d[{idx[1:0], 5'd0} +: DW] = in_data;
            end else if (idx < 5'd12) begin
                ad_d[{idx[1:0], 5'd0} +: DW] = in_data;
            end else if (idx < 5'd18) begin
                text_d[{toff, 5'd0} +: DW] = in_data;
            end else begin
                verif_d[{voff, 5'd0} +: DW] = in_data;
            end
`ifdef XOODYAK_LOADER_SHORTENC_EN
            if (is_final && in_last && !cur_op) begin
                verif_d = '0;
            end
`endif
        end
    end

    // Frame sequencing and framing-error detection.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (in_last != is_final) begin
                        frame_err = 1'b1;
                        state_d   = S_IDLE;
                        wcnt_d    = 5'd0;
                    end else if (is_final) begin
                        state_d = S_FIRE;
                        wcnt_d  = idx;
                    end else begin
                        state_d = S_LOAD;
                        wcnt_d  = idx + 5'd1;
                    end
                end
            end
            S_FIRE: begin
                // A done pulse coinciding with the start pulse belongs to no frame of ours.
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (core_done) begin
                    state_d = S_IDLE;
                    wcnt_d  = 5'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = 5'd0;
            end
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (frame_err) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 5'd0;
            key_q    <= '0;
            nonce_q  <= '0;
            ad_q     <= '0;
            text_q   <= '0;
            verif_q  <= '0;
            opmode_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            key_q    <= key_d;
            nonce_q  <= nonce_d;
            ad_q     <= ad_d;
            text_q   <= text_d;
            verif_q  <= verif_d;
            opmode_q <= opmode_d;
            err_q    <= err_d;
        end
    end

    assign key        = key_q;
    assign nonce      = nonce_q;
    assign assodata   = ad_q;
    assign textin     = text_q;
    assign verif_data = verif_q;
    assign opmode     = opmode_q;
    assign err        = err_q;
    assign start      = (state_q == S_FIRE);
    assign busy       = state_q[1];

endmodule

// File: tb/tb_xoodyak_frame_loader.sv
// Directed and randomized frames for xoodyak_frame_loader, checked against a word-array model of the frame layout.
module tb_xoodyak_frame_loader;

    logic         eph1 = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         in_opmode = 1'b0;
    logic         core_done = 1'b0;
    logic         err_clr = 1'b0;
    logic [127:0] key, nonce, assodata, verif_data;
    logic [191:0] textin;
    logic         opmode, start, busy, err;

    always #5 eph1 = ~eph1;

    xoodyak_frame_loader dut (
        .eph1(eph1), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_opmode(in_opmode),
        .core_done(core_done), .err_clr(err_clr), .key(key), .nonce(nonce),
        .assodata(assodata), .textin(textin), .verif_data(verif_data),
        .opmode(opmode), .start(start), .busy(busy), .err(err)
    );

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int exp_starts = 0;
    logic [31:0] w [22];

    always @(posedge eph1) if (start === 1'b1) start_cnt++;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chkw(input string tag, input logic [191:0] o, input logic [191:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chki(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge eph1);
        @(negedge eph1);
    endtask

    function automatic logic [127:0] blk(input int base);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[32*j +: 32] = w[base + j];
        return r;
    endfunction

    function automatic logic [191:0] txt();
        logic [191:0] r;
        for (int j = 0; j < 6; j++) r[32*j +: 32] = w[12 + j];
        return r;
    endfunction

    function automatic int frame_len(input bit opm);
`ifdef XOODYAK_LOADER_SHORTENC_EN
        return opm ? 22 : 18;
`else
        return 22;
`endif
    endfunction

    function automatic logic [127:0] exp_verif(input bit opm);
`ifdef XOODYAK_LOADER_SHORTENC_EN
        return opm ? blk(18) : 128'd0;
`else
        return blk(18);
`endif
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 22; i++) w[i] = $urandom;
    endtask

    task automatic fill_spec(input logic [127:0] vf);
        logic [127:0] kv, nv, av;
        logic [191:0] tv;
        kv = 128'h38393a3b3c3d3e3f3031323334353637;
        nv = 128'h494a4b4c4d4e4f404142434445464748;
        av = 128'h696a6b6c6d6e6f606162636465666768;
        tv = 192'h4d4e4f404142434445464748494a4b4c45464748494a4b4c;
        for (int j = 0; j < 4; j++) begin
            w[j]      = kv[32*j +: 32];
            w[4 + j]  = nv[32*j +: 32];
            w[8 + j]  = av[32*j +: 32];
            w[18 + j] = vf[32*j +: 32];
        end
        for (int j = 0; j < 6; j++) w[12 + j] = tv[32*j +: 32];
    endtask

    // gap: 0 back-to-back, 1 valid every other cycle, 2 random stalls with stray core_done
    task automatic send(input int n, input int last_at, input bit opm, input int gap);
        for (int i = 0; i < n; i++) begin
            if ((gap == 1 && i % 2 == 1) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid  = 1'b0;
                in_data   = $urandom;
                in_last   = 1'($urandom);
                core_done = (gap == 2) ? 1'($urandom) : 1'b0;
                for (int g = 0; g < ((gap == 2) ? $urandom_range(1, 4) : 1); g++) step();
                core_done = 1'b0;
            end
            in_valid  = 1'b1;
            in_data   = w[i];
            in_last   = (i == last_at);
            in_opmode = (i == 0) ? opm : ~opm;
            chk1("in_ready_load", in_ready, 1'b1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_fire(input bit opm);
        chk1("start_after_last", start, 1'b1);
        chk1("busy_fire", busy, 1'b1);
        chk1("in_ready_fire", in_ready, 1'b0);
        chkw("key", 192'(key), 192'(blk(0)));
        chkw("nonce", 192'(nonce), 192'(blk(4)));
        chkw("assodata", 192'(assodata), 192'(blk(8)));
        chkw("textin", textin, txt());
        chkw("verif_data", 192'(verif_data), 192'(exp_verif(opm)));
        chk1("opmode", opmode, opm);
        exp_starts++;
    endtask

    task automatic finish_core(input int hold, input bit done_in_fire);
        logic stall_ok;
        core_done = done_in_fire;
        step();
        core_done = 1'b0;
        chk1("start_single_cycle", start, 1'b0);
        chk1("busy_after_fire", busy, 1'b1);
        stall_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (in_ready !== 1'b0 || start !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
            step();
        end
        chk1("busy_hold_stall", stall_ok, 1'b1);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk1("busy_cleared", busy, 1'b0);
        chk1("in_ready_idle", in_ready, 1'b1);
        chki("start_count", start_cnt, exp_starts);
    endtask

    task automatic expect_err();
        chk1("err_set", err, 1'b1);
        chk1("no_start_on_err", start, 1'b0);
        chk1("busy_on_err", busy, 1'b0);
        chk1("in_ready_after_err", in_ready, 1'b1);
    endtask

    initial begin
        step();
        step();
        chk1("rst_in_ready", in_ready, 1'b0);
        chkw("rst_key", 192'(key), 192'd0);
        chkw("rst_textin", textin, 192'd0);
        chk1("rst_start", start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_opmode", opmode, 1'b0);
        reset_n = 1'b1;
        step();
        chk1("idle_in_ready", in_ready, 1'b1);

        // Reference frame back-to-back, then with valid toggling and a long core delay.
        fill_spec(128'd0);
        send(22, 21, 1'b0, 0);
        chkw("spec_key", 192'(key), 192'(128'h38393a3b3c3d3e3f3031323334353637));
        chkw("spec_ad", 192'(assodata), 192'(128'h696a6b6c6d6e6f606162636465666768));
        expect_fire(1'b0);
        finish_core(3, 1'b0);

        send(22, 21, 1'b0, 1);
        expect_fire(1'b0);
        finish_core(50, 1'b0);

        // Early in_last is a framing error; the following good frame still fires.
        fill_random();
        send(11, 10, 1'b0, 0);
        expect_err();
        fill_random();
        send(22, 21, 1'b1, 2);
        expect_fire(1'b1);
        chk1("err_sticky", err, 1'b1);
        finish_core(2, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk1("err_cleared", err, 1'b0);

        // Missing in_last on the final word.
        fill_random();
        send(22, -1, 1'b1, 0);
        expect_err();
        chki("no_start_missing_last", start_cnt, exp_starts);

        // New error together with err_clr keeps err set.
        err_clr = 1'b1;
        send(1, 0, 1'b0, 0);
        err_clr = 1'b0;
        expect_err();

        // Asynchronous reset in the middle of loading.
        fill_random();
        w[0] = w[0] | 32'h1;
        send(7, -1, 1'b1, 0);
        chk1("pre_rst_in_ready", in_ready, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chkw("arst_key", 192'(key), 192'd0);
        chkw("arst_textin", textin, 192'd0);
        chk1("arst_err", err, 1'b0);
        chk1("arst_in_ready", in_ready, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        @(negedge eph1);
        reset_n = 1'b1;
        step();
        fill_random();
        send(22, 21, 1'b0, 0);
        chkw("post_rst_frame", 192'(key), 192'(blk(0)));
        expect_fire(1'b0);
        finish_core(1, 1'b0);

        // Decrypt frame with a fixed tag.
        fill_spec({4{32'hA5A5A5A5}});
        send(22, 21, 1'b1, 0);
        chkw("verif_a5", 192'(verif_data), 192'({4{32'hA5A5A5A5}}));
        expect_fire(1'b1);
        finish_core(4, 1'b0);

        // in_last on word 17: a complete short encrypt frame, or a framing error without the option.
        fill_random();
`ifdef XOODYAK_LOADER_SHORTENC_EN
        send(18, 17, 1'b0, 0);
        expect_fire(1'b0);
        finish_core(2, 1'b0);
`else
        send(18, 17, 1'b0, 0);
        expect_err();
        chki("no_start_word17", start_cnt, exp_starts);
`endif
        fill_random();
        send(18, 17, 1'b1, 0);
        expect_err();

        // Randomized frames with stalls.
        for (int f = 0; f < 4; f++) begin
            bit opm;
            opm = 1'($urandom);
            fill_random();
            send(frame_len(opm), frame_len(opm) - 1, opm, 2);
            expect_fire(opm);
            finish_core($urandom_range(0, 6), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
